// File: rtl/voice_mixer.sv
// Time-multiplexed N-voice mixer: per-voice gain, accumulate, master shift, saturate to SAMPLE_W.
// Optional MIXER_ACTIVE_NORM_EN: shift derived from the number of active voices instead of master_shift.
module voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W   = 24,
  parameter int GAIN_W     = 9
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
  input  logic [2:0]                     master_shift,
  output logic [SAMPLE_W-1:0]            mixer_output,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           sat_flag,
  output logic                           overrun
);

  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int TERM_W = PROD_W - 8;
  localparam int ACC_W  = SAMPLE_W + 1 + $clog2(NUM_VOICES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [SAMPLE_W-1:0]           mix_q, mix_d;
  logic                          valid_q, valid_d;
  logic                          sat_q, sat_d;
  logic                          overrun_q, overrun_d;
  logic                          load;

  logic [NUM_VOICES*SAMPLE_W-1:0] samples_q;
  logic [NUM_VOICES-1:0]          active_q;
  logic [NUM_VOICES*GAIN_W-1:0]   gain_q;
  logic [2:0]                     shift_q;
  logic [2:0]                     shift_in;

`ifdef MIXER_ACTIVE_NORM_EN
  function automatic logic [2:0] norm_shift(input logic [NUM_VOICES-1:0] act);
    int cnt;
    int s;
    cnt = 0;
    s   = 0;
    for (int v = 0; v < NUM_VOICES; v++) cnt += int'(act[v]);
    for (int k = 0; k < 7; k++) if ((1 << k) < cnt) s = k + 1;
    return 3'(s);
  endfunction

  logic unused_master_shift;
  assign unused_master_shift = ^master_shift;
  assign shift_in = norm_shift(voice_active);
`else
  assign shift_in = master_shift;
`endif

  // Datapath for the voice selected this cycle.
  logic signed [SAMPLE_W-1:0] sample_sel;
  logic [GAIN_W-1:0]          gain_sel;
  logic signed [PROD_W-1:0]   prod;
  logic signed [TERM_W-1:0]   term;

  assign sample_sel = samples_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
  assign gain_sel   = gain_q[int'(idx_q)*GAIN_W +: GAIN_W];
  assign prod       = sample_sel * $signed({1'b0, gain_sel});
  assign term       = prod[PROD_W-1:8];

  // Final shift and saturation: clipped when the bits above the output sign disagree with it.
  logic signed [ACC_W-1:0] shifted;
  logic                    pos_clip, neg_clip;
  logic [SAMPLE_W-1:0]     sat_result;

  assign shifted  = acc_q >>> shift_q;
  assign pos_clip = !shifted[ACC_W-1] &&  (|shifted[ACC_W-2:SAMPLE_W-1]);
  assign neg_clip =  shifted[ACC_W-1] && !(&shifted[ACC_W-2:SAMPLE_W-1]);

  always_comb begin
    sat_result = shifted[SAMPLE_W-1:0];
    if (pos_clip)      sat_result = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (neg_clip) sat_result = {1'b1, {(SAMPLE_W-1){1'b0}}};
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    sat_d     = 1'b0;
    overrun_d = overrun_q;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          load    = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (active_q[idx_q]) acc_d = acc_q + ACC_W'(term);
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        mix_d   = sat_result;
        valid_d = 1'b1;
        sat_d   = pos_clip || neg_clip;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: latched operands need no reset; they are only read after a load in IDLE overwrites them.
  always_ff @(posedge clk) begin
    if (load) begin
      samples_q <= voice_samples;
      active_q  <= voice_active;
      gain_q    <= voice_gain;
      shift_q   <= shift_in;
    end
  end

  assign mixer_output = mix_q;
  assign out_valid    = valid_q;
  assign sat_flag     = sat_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer (8 voices, 24-bit samples, 9-bit gains).
module tb_voice_mixer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sample_tick;
  logic [191:0] voice_samples;
  logic [7:0]   voice_active;
  logic [71:0]  voice_gain;
  logic [2:0]   master_shift;
  logic [23:0]  mixer_output;
  logic         out_valid;
  logic         busy;
  logic         sat_flag;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_mixer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .voice_samples (voice_samples),
    .voice_active  (voice_active),
    .voice_gain    (voice_gain),
    .master_shift  (master_shift),
    .mixer_output  (mixer_output),
    .out_valid     (out_valid),
    .busy          (busy),
    .sat_flag      (sat_flag),
    .overrun       (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_voices(input logic [23:0] smp, input logic [8:0] g,
                            input logic [7:0] mask, input logic [2:0] sh);
    for (int i = 0; i < 8; i++) begin
      voice_samples[i*24 +: 24] = smp;
      voice_gain[i*9 +: 9]      = g;
    end
    voice_active = mask;
    master_shift = sh;
  endtask

  // Pulses sample_tick, scrambles inputs after the latch edge, and returns the edge count to out_valid.
  task automatic run_mix(output int lat);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("busy_after_tick", busy, 1);
    voice_samples = {6{$urandom}};
    voice_gain    = 72'({3{$urandom}});
    voice_active  = 8'($urandom);
    master_shift  = 3'($urandom);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat;
  int pulses;
  int first;

  initial begin
    reset_n      = 1'b0;
    sample_tick  = 1'b0;
    set_voices(24'd0, 9'd0, 8'h00, 3'd0);
    repeat (3) @(negedge clk);
    check("rst_mixer_output", mixer_output, 0);
    check("rst_out_valid",    out_valid, 0);
    check("rst_busy",         busy, 0);
    check("rst_sat_flag",     sat_flag, 0);
    check("rst_overrun",      overrun, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single active voice at unity gain.
    set_voices(24'd1000, 9'd256, 8'h01, 3'd0);
    run_mix(lat);
    check("t1_latency", lat, 9);
    check("t1_output",  mixer_output, 24'd1000);
    check("t1_sat",     sat_flag, 0);
    check("t1_busy_at_valid", busy, 0);
    @(negedge clk);
    check("t1_valid_pulse_end", out_valid, 0);
    check("t1_sat_low",         sat_flag, 0);
    check("t1_output_held",     mixer_output, 24'd1000);

    // Positive full scale on all voices.
    set_voices(24'h7FFFFF, 9'd256, 8'hFF, 3'd0);
    run_mix(lat);
    check("t2a_latency", lat, 9);
    check("t2a_output",  mixer_output, 24'h7FFFFF);
`ifdef MIXER_ACTIVE_NORM_EN
    check("t2a_sat", sat_flag, 0);
`else
    check("t2a_sat", sat_flag, 1);
`endif
    set_voices(24'h7FFFFF, 9'd256, 8'hFF, 3'd3);
    run_mix(lat);
    check("t2b_output", mixer_output, 24'h7FFFFF);
    check("t2b_sat",    sat_flag, 0);

    // Negative full scale at max gain, and floor behaviour of the gain shift.
    set_voices(24'h800000, 9'd511, 8'hFF, 3'd0);
    run_mix(lat);
    check("t3a_output", mixer_output, 24'h800000);
    check("t3a_sat",    sat_flag, 1);
    set_voices(24'hFFFFFF, 9'd128, 8'h01, 3'd0);
    run_mix(lat);
    check("t3b_output", mixer_output, 24'hFFFFFF);
    check("t3b_sat",    sat_flag, 0);
    check("t3b_no_overrun", overrun, 0);

    // Second tick three cycles into a mix.
    set_voices(24'd500, 9'd256, 8'h01, 3'd0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
      sample_tick = (i == 2);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    check("t4_pulses",  pulses, 1);
    check("t4_first",   first, 9);
    check("t4_output",  mixer_output, 24'd500);
    check("t4_overrun", overrun, 1);
    set_voices(24'hFFF830, 9'd256, 8'h01, 3'd0);
    run_mix(lat);
    check("t4_next_latency", lat, 9);
    check("t4_next_output",  mixer_output, 24'hFFF830);
    check("t4_overrun_sticky", overrun, 1);

    // Reset in the middle of accumulation.
    set_voices(24'd777, 9'd256, 8'h01, 3'd0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy_before_rst", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_output",  mixer_output, 0);
    check("t5_busy",    busy, 0);
    check("t5_valid",   out_valid, 0);
    check("t5_sat",     sat_flag, 0);
    check("t5_overrun", overrun, 0);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("t5_no_valid", pulses, 0);
    set_voices(24'd777, 9'd256, 8'h01, 3'd0);
    run_mix(lat);
    check("t5_next_latency", lat, 9);
    check("t5_next_output",  mixer_output, 24'd777);

    // Three active voices: normalised shift or plain sum.
    set_voices(24'd4000, 9'd256, 8'h07, 3'd0);
    run_mix(lat);
    check("t6_latency", lat, 9);
`ifdef MIXER_ACTIVE_NORM_EN
    check("t6_output", mixer_output, 24'd3000);
`else
    check("t6_output", mixer_output, 24'd12000);
`endif
    check("t6_sat", sat_flag, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
